nb_limit_ctl: RTL and testbench
===============================

# nb_limit_ctl

Adaptive threshold controller for the noise blanker. It watches the same interleaved X/Y sample stream the blanker sees and measures the mean magnitude over fixed windows. From that mean it drives the blanker's 8-bit `limit` input. When too many samples exceed the limit in one window, it backs off and parks the limit at 255 for a programmable number of windows, so strong wanted signals are not blanked.

## Interface
- `WLOG`, 10: log2 of window length in valid samples (X and Y both count); legal range 2..12.
- `clk` in 1: double-rate sample clock shared with the blanker.
- `rst` in 1: reset, synchronous, active-low (0 = reset).
- `dixy` in 18: sample, two's complement; X when `iq`=0, Y when `iq`=1.
- `iv` in 1: input valid.
- `iq` in 1: 0 = X sample, 1 = Y sample.
- `en` in 1: 1 = adaptive control on; 0 = limit forced to 255.
- `mult` in 4: limit gain, in units of 1/4 (limit = mean·mult/4).
- `floor` in 8: minimum limit.
- `maxhits` in 8: hit count above which backoff occurs.
- `holdoff` in 4: extra backoff windows.
- `limit` out 8: threshold to the blanker.
- `upd` out 1: one-cycle pulse when `limit` is rewritten at a window end.
- `state` out 2: 0 OFF, 1 ACQ, 2 TRACK, 3 BACKOFF.
- `mean` out 8: mean magnitude of the last completed window.
- `hits` out 16: hit count of the last completed window, saturating.

## Operation
- Magnitude: `mag` = `dixy[16:9]` XOR {8{`dixy[17]`}} (one's complement), range 0..255, registered when `iv`=1.
- Hit: a valid sample with `mag` > the current `limit` output increments the window hit counter. The counter is 16-bit and saturates at 65535.
- Accumulator: width 8+`WLOG`; the sum of `mag` over 2^`WLOG` valid samples. Window mean = acc >> `WLOG`.
- Window framing: a window starts at the first valid X sample after entering ACQ. It ends on the 2^`WLOG`-th valid sample, which is always a Y sample. Windows are back-to-back with no gap.
- Candidate limit: p = (mean·`mult`) >> 2 (10 bits). Saturate p to 255, then take max(p, `floor`). `mult`=0 yields `floor`.
- `mult`, `floor`, `maxhits` and `holdoff` are sampled only at the window end; changes mid-window take effect at the next window end.
- FSM:
  - **OFF**: `limit`=255; counters and the alignment flag are cleared. `en`=1 → ACQ.
  - **ACQ**: wait for X alignment, then accumulate one window. At the window end, `limit` ← candidate, `upd`, → TRACK.
  - **TRACK**: at each window end:
    - if hits > `maxhits`: `limit` ← 255, backoff counter ← `holdoff`, `upd`, → BACKOFF;
    - otherwise `limit` ← candidate, `upd`.
  - **BACKOFF**: `limit` held at 255. At each window end:
    - if counter = 0: `limit` ← candidate, `upd`, → TRACK;
    - otherwise decrement the counter.
    - Backoff therefore lasts `holdoff`+1 windows.
- `en`=0 in any state → OFF at the next edge. `limit` becomes 255 at that edge and the partial window is discarded; no `upd` is generated.
- At every window end, `mean` and `hits` latch, in all states except OFF.

## Timing
- Reset values: `limit`=255, `upd`=0, `state`=0, `mean`=0, `hits`=0. All internal counters are 0.
- Reset asserted mid-window: reset values appear at the next edge and the partial window is lost.
- Pipeline:
  - stage 1: `mag`/valid/iq registered;
  - stage 2: accumulate, hit count, window-end flag;
  - stage 3: product and decision registered;
  - `limit`, `upd`, `mean`, `hits` and `state` all change together 3 clk after the `iv` cycle of the window's last sample.
- Hit comparison uses `limit` as registered at stage 2. Samples within 3 clk after an update are compared against the old limit.
- `iv` may drop for any number of cycles; the window counts only valid samples.

## Structure
- Shared package `nb_pkg`:
  - FSM state encoding (OFF/ACQ/TRACK/BACKOFF);
  - `NB_MAG_W` = 8;
  - `NB_LIMIT_MAX` = 8'd255;
  - hit-counter width 16.
- One sub-module, `nb_mag`: one's-complement 8-bit magnitude register with CE = `iv` and active-low sync reset.
- The top level holds the accumulator, counters, multiplier and FSM.

## Test plan
All scenarios use `WLOG`=4 (16-sample windows) unless noted.
- Constant `dixy`=18'h0A000 (mag 80), `mult`=8, `floor`=16, `en`=1 → after the first window, `limit`=160, `upd` once, `state`=TRACK, `mean`=80.
- mag 200, `mult`=15 → candidate 750 saturates: `limit`=255. Then mag 2, `floor`=16 → `limit`=16.
- Negative sample `dixy`=18'h20000 (mag 255) with X/Y alternation and `iv` gaps of 0–5 cycles → windows end only on Y; `mean` is exact.
- In TRACK with `limit`=40, `maxhits`=3, 5 samples of mag 255 in one window → BACKOFF, `limit`=255. With `holdoff`=2 and quiet input (mag 10, `mult`=8), TRACK resumes after 3 windows with `limit`=20.
- `en` dropped mid-window → next edge `state`=OFF, `limit`=255, no `upd`. Re-enable → ACQ realigns on the next X sample.
- `rst`=0 mid-window in TRACK → all outputs at reset values next edge. `mult` changed mid-window → applied only at that window's end.

Source files
------------

// File: rtl/nb_pkg.sv
// Shared types and constants for the noise-blanker limit controller.
// Includes the candidate-limit helper used at each window end.
package nb_pkg;

    typedef enum logic [1:0] {
        StOff     = 2'd0,
        StAcq     = 2'd1,
        StTrack   = 2'd2,
        StBackoff = 2'd3
    } nb_state_e;

    localparam int unsigned NB_MAG_W     = 8;
    localparam logic [7:0]  NB_LIMIT_MAX = 8'd255;
    localparam int unsigned NB_HIT_W     = 16;

    // (mean * mult) / 4, saturated to 8 bits, then raised to the floor.
    function automatic logic [7:0] nb_candidate(input logic [7:0] mean,
                                                input logic [3:0] mult,
                                                input logic [7:0] flr);
        logic [11:0] prod;
        logic [9:0]  p;
        logic [7:0]  sat;
        prod = {4'b0, mean} * {8'b0, mult};
        p    = prod[11:2];
        sat  = (p > 10'd255) ? 8'hFF : p[7:0];
        return (sat > flr) ? sat : flr;
    endfunction

endpackage

// File: rtl/nb_limit_ctl_if.sv
// Sample stream, configuration and status bundle between the blanker side and
// the adaptive limit controller.
interface nb_limit_ctl_if;
    import nb_pkg::*;

    logic [17:0]          dixy;
    logic                 iv;
    logic                 iq;
    logic                 en;
    logic [3:0]           mult;
    logic [7:0]           floor;
    logic [7:0]           maxhits;
    logic [3:0]           holdoff;
    logic [NB_MAG_W-1:0]  limit;
    logic                 upd;
    logic [1:0]           state;
    logic [NB_MAG_W-1:0]  mean;
    logic [NB_HIT_W-1:0]  hits;

    modport master (
        output dixy, iv, iq, en, mult, floor, maxhits, holdoff,
        input  limit, upd, state, mean, hits
    );

    modport slave (
        input  dixy, iv, iq, en, mult, floor, maxhits, holdoff,
        output limit, upd, state, mean, hits
    );

endinterface

// File: rtl/nb_mag.sv
// One's-complement 8-bit magnitude of an 18-bit sample, registered when ce_i=1.
module nb_mag
    import nb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ce_i,
    input  logic [17:0]         dixy_i,
    output logic [NB_MAG_W-1:0] mag_o
);

    logic [NB_MAG_W-1:0] mag_d, mag_q;
    logic                unused_lsb;

    assign unused_lsb = ^dixy_i[8:0];

    always_comb begin
        mag_d = mag_q;
        if (ce_i) begin
            mag_d = dixy_i[16:9] ^ {NB_MAG_W{dixy_i[17]}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mag_q <= '0;
        end else begin
            mag_q <= mag_d;
        end
    end

    assign mag_o = mag_q;

endmodule

// File: rtl/nb_limit_ctl.sv
// Adaptive noise-blanker threshold: windowed mean magnitude drives the limit,
// with a hit-count backoff that parks the limit at full scale.
module nb_limit_ctl
    import nb_pkg::*;
#(
    parameter int unsigned WLOG = 10
) (
    input  logic           clk,
    input  logic           rst,
    nb_limit_ctl_if.slave  bus
);

    localparam int unsigned AccW = NB_MAG_W + WLOG;

    logic [NB_MAG_W-1:0] mag1;
    logic                v1_d, v1_q, iq1_d, iq1_q;

    logic [AccW-1:0]     acc_d, acc_q, acc_base;
    logic [WLOG-1:0]     cnt_d, cnt_q;
    logic [NB_HIT_W-1:0] hcnt_d, hcnt_q, hcnt_base;
    logic                aligned_d, aligned_q, wend_d, wend_q;
    logic                active, counted, hit;

    nb_state_e           state_d, state_q;
    logic [7:0]          limit_d, limit_q, mean_d, mean_q, mean_w, cand;
    logic [NB_HIT_W-1:0] hits_d, hits_q;
    logic [3:0]          boff_d, boff_q;
    logic                upd_d, upd_q;

    nb_mag u_mag (
        .clk_i  (clk),
        .rst_ni (rst),
        .ce_i   (bus.iv),
        .dixy_i (bus.dixy),
        .mag_o  (mag1)
    );

    // Stage 1 side-band alongside the magnitude register.
    always_comb begin
        v1_d  = bus.iv;
        iq1_d = bus.iq;
    end

    // Stage 2: accumulate and count; the window restarts the cycle after wend_q.
    always_comb begin
        active    = bus.en && (state_q != StOff);
        counted   = v1_q && (aligned_q || !iq1_q);
        hit       = mag1 > limit_q;
        acc_base  = wend_q ? '0 : acc_q;
        hcnt_base = wend_q ? '0 : hcnt_q;
        acc_d     = acc_base;
        hcnt_d    = hcnt_base;
        cnt_d     = cnt_q;
        aligned_d = aligned_q;
        wend_d    = 1'b0;
        if (!active) begin
            acc_d     = '0;
            hcnt_d    = '0;
            cnt_d     = '0;
            aligned_d = 1'b0;
        end else if (counted) begin
            aligned_d = 1'b1;
            acc_d     = acc_base + AccW'(mag1);
            hcnt_d    = (hit && (hcnt_base != '1)) ? hcnt_base + 16'd1 : hcnt_base;
            cnt_d     = cnt_q + WLOG'(1);
            wend_d    = (cnt_q == '1);
        end
    end

    // Stage 3: window-end decision and FSM.
    always_comb begin
        mean_w  = acc_q[AccW-1 -: NB_MAG_W];
        cand    = nb_candidate(mean_w, bus.mult, bus.floor);
        state_d = state_q;
        limit_d = limit_q;
        mean_d  = mean_q;
        hits_d  = hits_q;
        boff_d  = boff_q;
        upd_d   = 1'b0;
        if (!bus.en) begin
            state_d = StOff;
            limit_d = NB_LIMIT_MAX;
            boff_d  = '0;
        end else if (state_q == StOff) begin
            state_d = StAcq;
        end else if (wend_q) begin
            mean_d = mean_w;
            hits_d = hcnt_q;
            unique case (state_q)
                StAcq: begin
                    limit_d = cand;
                    upd_d   = 1'b1;
                    state_d = StTrack;
                end
                StTrack: begin
                    upd_d = 1'b1;
                    if (hcnt_q > {8'b0, bus.maxhits}) begin
                        limit_d = NB_LIMIT_MAX;
                        boff_d  = bus.holdoff;
                        state_d = StBackoff;
                    end else begin
                        limit_d = cand;
                    end
                end
                StBackoff: begin
                    if (boff_q == 4'd0) begin
                        limit_d = cand;
                        upd_d   = 1'b1;
                        state_d = StTrack;
                    end else begin
                        boff_d = boff_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            iq1_q     <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            aligned_q <= 1'b0;
            wend_q    <= 1'b0;
            state_q   <= StOff;
            limit_q   <= NB_LIMIT_MAX;
            mean_q    <= '0;
            hits_q    <= '0;
            boff_q    <= '0;
            upd_q     <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            iq1_q     <= iq1_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            aligned_q <= aligned_d;
            wend_q    <= wend_d;
            state_q   <= state_d;
            limit_q   <= limit_d;
            mean_q    <= mean_d;
            hits_q    <= hits_d;
            boff_q    <= boff_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.limit = limit_q;
    assign bus.upd   = upd_q;
    assign bus.state = state_q;
    assign bus.mean  = mean_q;
    assign bus.hits  = hits_q;

endmodule

// File: tb/tb_nb_limit_ctl.sv
// Directed bench for nb_limit_ctl with 16-sample windows: a window-level vector
// table plus hand sequences for timing, enable drop and mid-window reset.
module tb_nb_limit_ctl;
    import nb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nb_limit_ctl_if bus_if ();

    nb_limit_ctl #(.WLOG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int errors  = 0;
    int checks  = 0;
    int upd_cnt = 0;
    logic iq_next;

    always @(negedge clk) if (bus_if.upd === 1'b1) upd_cnt++;

    typedef struct {
        logic [17:0] da;
        int          na;
        logic [17:0] db;
        int          gmax;
        logic [3:0]  mult;
        logic [7:0]  flr;
        logic [7:0]  maxh;
        logic [3:0]  hold;
        int          e_limit;
        int          e_state;
        int          e_mean;
        int          e_hits;
        int          e_upd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [17:0] d, input logic q);
        @(posedge clk);
        #1;
        bus_if.dixy = d;
        bus_if.iq   = q;
        bus_if.iv   = 1'b1;
    endtask

    task automatic send_x(input logic [17:0] d);
        send(d, iq_next);
        iq_next = ~iq_next;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus_if.iv = 1'b0;
        end
    endtask

    task automatic set_cfg(input logic [3:0] m, input logic [7:0] f,
                           input logic [7:0] mh, input logic [3:0] h);
        bus_if.mult    = m;
        bus_if.floor   = f;
        bus_if.maxhits = mh;
        bus_if.holdoff = h;
    endtask

    task automatic chk_win(input string tag, input int lim, input int st, input int mn,
                           input int ht);
        chk({tag, ".limit"}, int'(bus_if.limit), lim);
        chk({tag, ".state"}, int'(bus_if.state), st);
        chk({tag, ".mean"},  int'(bus_if.mean),  mn);
        chk({tag, ".hits"},  int'(bus_if.hits),  ht);
    endtask

    initial begin
        int u0;
        // mag m positive: dixy = m << 9; 18'h3FA00 is negative with mag 2.
        vecs[0] = '{18'h0A000, 16, 18'h00000, 0, 4'd8,  8'd16, 8'd255, 4'd0, 160, 2,  80,  0, 1};
        vecs[1] = '{18'h19000, 16, 18'h00000, 0, 4'd15, 8'd16, 8'd255, 4'd0, 255, 2, 200, 16, 1};
        vecs[2] = '{18'h3FA00, 16, 18'h00000, 0, 4'd8,  8'd16, 8'd255, 4'd0,  16, 2,   2,  0, 1};
        vecs[3] = '{18'h02800, 16, 18'h00000, 0, 4'd8,  8'd16, 8'd255, 4'd0,  40, 2,  20, 16, 1};
        vecs[4] = '{18'h20000,  5, 18'h02800, 0, 4'd8,  8'd16, 8'd3,   4'd2, 255, 3,  93,  5, 1};
        vecs[5] = '{18'h01400, 16, 18'h00000, 0, 4'd8,  8'd16, 8'd3,   4'd2, 255, 3,  10,  0, 0};
        vecs[6] = '{18'h01400, 16, 18'h00000, 0, 4'd8,  8'd16, 8'd3,   4'd2, 255, 3,  10,  0, 0};
        vecs[7] = '{18'h01400, 16, 18'h00000, 0, 4'd8,  8'd16, 8'd3,   4'd2,  20, 2,  10,  0, 1};
        vecs[8] = '{18'h0C800, 16, 18'h00000, 0, 4'd0,  8'd50, 8'd255, 4'd0,  50, 2, 100, 16, 1};
        vecs[9] = '{18'h20000, 16, 18'h00000, 5, 4'd4,  8'd0,  8'd255, 4'd0, 255, 2, 255, 16, 1};

        rst         = 1'b0;
        bus_if.en   = 1'b0;
        bus_if.iv   = 1'b0;
        bus_if.iq   = 1'b0;
        bus_if.dixy = '0;
        set_cfg(4'd8, 8'd16, 8'd255, 4'd0);
        iq_next = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.limit", int'(bus_if.limit), 255);
        chk("rst.upd",   int'(bus_if.upd),   0);
        chk("rst.state", int'(bus_if.state), 0);
        chk("rst.mean",  int'(bus_if.mean),  0);
        chk("rst.hits",  int'(bus_if.hits),  0);

        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus_if.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en.state_acq", int'(bus_if.state), 1);

        for (int v = 0; v < 10; v++) begin
            @(posedge clk);
            #1;
            set_cfg(vecs[v].mult, vecs[v].flr, vecs[v].maxh, vecs[v].hold);
            u0 = upd_cnt;
            for (int i = 0; i < 16; i++) begin
                send_x((i < vecs[v].na) ? vecs[v].da : vecs[v].db);
                if (vecs[v].gmax > 0) idle(i % (vecs[v].gmax + 1));
            end
            idle(6);
            @(negedge clk);
            chk_win($sformatf("vec%0d", v), vecs[v].e_limit, vecs[v].e_state,
                    vecs[v].e_mean, vecs[v].e_hits);
            chk($sformatf("vec%0d.upd", v), upd_cnt - u0, vecs[v].e_upd);
        end

        // Latency and mid-window mult change: only the value at window end counts.
        set_cfg(4'd8, 8'd0, 8'd255, 4'd0);
        for (int i = 0; i < 16; i++) begin
            send_x(18'h05000);
            if (i == 7) bus_if.mult = 4'd12;
        end
        @(posedge clk);
        #1;
        bus_if.iv = 1'b0;
        @(negedge clk);
        chk("lat.upd_e0",   int'(bus_if.upd),   0);
        chk("lat.limit_e0", int'(bus_if.limit), 255);
        @(negedge clk);
        chk("lat.upd_e1",   int'(bus_if.upd),   0);
        @(negedge clk);
        chk("lat.upd_e2",   int'(bus_if.upd),   1);
        chk_win("multchg", 120, 2, 40, 0);

        // Enable dropped mid-window.
        idle(4);
        u0 = upd_cnt;
        for (int i = 0; i < 6; i++) send_x(18'h0A000);
        @(posedge clk);
        #1;
        bus_if.iv = 1'b0;
        bus_if.en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("endrop.state", int'(bus_if.state), 0);
        chk("endrop.limit", int'(bus_if.limit), 255);
        idle(6);
        chk("endrop.mean", int'(bus_if.mean), 40);
        chk("endrop.upd",  upd_cnt - u0, 0);

        // Re-enable: a leading Y sample must not open the window.
        bus_if.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reen.state", int'(bus_if.state), 1);
        chk("reen.limit", int'(bus_if.limit), 255);
        set_cfg(4'd8, 8'd16, 8'd255, 4'd0);
        u0 = upd_cnt;
        send(18'h00000, 1'b1);
        iq_next = 1'b0;
        for (int i = 0; i < 16; i++) send_x(18'h0A000);
        idle(6);
        @(negedge clk);
        chk_win("realign", 160, 2, 80, 0);
        chk("realign.upd", upd_cnt - u0, 1);

        // Reset mid-window in TRACK: partial window must vanish.
        @(posedge clk);
        #1;
        iq_next = 1'b0;
        for (int i = 0; i < 5; i++) send_x(18'h19000);
        @(posedge clk);
        #1;
        bus_if.iv = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst.limit", int'(bus_if.limit), 255);
        chk("midrst.upd",   int'(bus_if.upd),   0);
        chk("midrst.state", int'(bus_if.state), 0);
        chk("midrst.mean",  int'(bus_if.mean),  0);
        chk("midrst.hits",  int'(bus_if.hits),  0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        u0 = upd_cnt;
        iq_next = 1'b0;
        for (int i = 0; i < 16; i++) send_x(18'h0A000);
        idle(6);
        @(negedge clk);
        chk_win("postrst", 160, 2, 80, 0);
        chk("postrst.upd", upd_cnt - u0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
